// File: rtl/pd_usb_tx_serializer.sv
// USB-style transmit serializer for the packet datapath.
// Fetches 16-bit words from the upstream stage and sends each one high byte
// first, LSB first within each byte. The bit stream is bit-stuffed and NRZI
// encoded, then closed with an EOP (two bit times of SE0, one bit time of J).
// data_sent pulses once when the packet is complete.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | line at J, waiting for start
// LOAD    | read_enable high, first word captured at the end of the cycle
// SHIFT   | one data bit on the line, held CLKS_PER_BIT clocks
// STUFF   | stuffed 0 after six consecutive 1s, held CLKS_PER_BIT clocks
// EOP_SE0 | both lines low for 2*CLKS_PER_BIT clocks
// EOP_J   | line at J for CLKS_PER_BIT clocks
// DONE    | data_sent high for one clock, then back to IDLE

module pd_usb_tx_serializer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int NUM_WORDS    = 20
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        start,
   input  logic [15:0] tx_data,
   output logic        read_enable,
   output logic        data_sent,
   output logic        busy,
   output logic        dplus,
   output logic        dminus
);

   localparam int CLK_W  = $clog2(2 * CLKS_PER_BIT);
   localparam int WORD_W = $clog2(NUM_WORDS + 1);

   localparam logic [CLK_W-1:0]  BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [CLK_W-1:0]  SE0_LAST = CLK_W'(2 * CLKS_PER_BIT - 1);
   localparam logic [CLK_W-1:0]  CNT_ONE  = CLK_W'(1);
   localparam logic [WORD_W-1:0] WORD_ONE = WORD_W'(1);
   localparam logic [WORD_W-1:0] WORD_ALL = WORD_W'(NUM_WORDS);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      STUFF   = 3'd3,
      EOP_SE0 = 3'd4,
      EOP_J   = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t             state_q, state_d;
   logic [15:0]        shift_reg_q, shift_reg_d;
   logic [CLK_W-1:0]   clk_cnt_q, clk_cnt_d;
   logic [3:0]         bit_idx_q, bit_idx_d;
   logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
   logic [2:0]         stuff_cnt_q, stuff_cnt_d;
   logic               dplus_q, dplus_d;
   logic               dminus_q, dminus_d;
   logic               read_enable_q, read_enable_d;
   logic               data_sent_q, data_sent_d;
   logic               busy_q, busy_d;

   logic               stuff_due;
   logic               more_words;
   logic               last_bit;
   logic               advance;
   logic               next_bit;
   logic [CLK_W-1:0]   clk_dec;

   // The shift register holds the word byte-swapped so that shifting right
   // yields tx_data[8..15] followed by tx_data[0..7]; bit 0 is on the line.
   // A stuff is due when the bit now on the line is the sixth 1 in a row.
   assign stuff_due  = shift_reg_q[0] & (stuff_cnt_q == 3'd5);
   assign more_words = (word_cnt_q != WORD_ALL);
   assign last_bit   = (bit_idx_q == 4'd15);
   assign clk_dec    = clk_cnt_q - CNT_ONE;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d       = state_q;
      shift_reg_d   = shift_reg_q;
      clk_cnt_d     = clk_cnt_q;
      bit_idx_d     = bit_idx_q;
      word_cnt_d    = word_cnt_q;
      stuff_cnt_d   = stuff_cnt_q;
      dplus_d       = dplus_q;
      dminus_d      = dminus_q;
      read_enable_d = 1'b0;
      data_sent_d   = 1'b0;
      advance       = 1'b0;
      next_bit      = 1'b1;

      case (state_q)
         IDLE: begin
            dplus_d  = 1'b1;
            dminus_d = 1'b0;
            if (start) begin
               state_d       = LOAD;
               read_enable_d = 1'b1;
            end
         end

         LOAD: begin
            state_d     = SHIFT;
            shift_reg_d = {tx_data[7:0], tx_data[15:8]};
            word_cnt_d  = WORD_ONE;
            bit_idx_d   = 4'd0;
            stuff_cnt_d = 3'd0;
            clk_cnt_d   = BIT_LAST;
            if (!tx_data[8]) begin
               dplus_d  = ~dplus_q;
               dminus_d = ~dminus_q;
            end
         end

         SHIFT: begin
            clk_cnt_d = clk_dec;
            // read_enable is registered, so it is raised one clock early to
            // land on the last clock of bit 15 when no stuff follows it.
            if ((clk_cnt_q == CNT_ONE) && last_bit && !stuff_due && more_words) begin
               read_enable_d = 1'b1;
            end
            if (clk_cnt_q == '0) begin
               if (stuff_due) begin
                  state_d     = STUFF;
                  stuff_cnt_d = 3'd0;
                  clk_cnt_d   = BIT_LAST;
                  dplus_d     = ~dplus_q;
                  dminus_d    = ~dminus_q;
               end else begin
                  stuff_cnt_d = shift_reg_q[0] ? (stuff_cnt_q + 3'd1) : 3'd0;
                  advance     = 1'b1;
               end
            end
         end

         STUFF: begin
            clk_cnt_d = clk_dec;
            if ((clk_cnt_q == CNT_ONE) && last_bit && more_words) begin
               read_enable_d = 1'b1;
            end
            if (clk_cnt_q == '0) begin
               advance = 1'b1;
            end
         end

         EOP_SE0: begin
            clk_cnt_d = clk_dec;
            if (clk_cnt_q == '0) begin
               state_d   = EOP_J;
               clk_cnt_d = BIT_LAST;
               dplus_d   = 1'b1;
               dminus_d  = 1'b0;
            end
         end

         EOP_J: begin
            clk_cnt_d = clk_dec;
            if (clk_cnt_q == '0) begin
               state_d     = DONE;
               clk_cnt_d   = '0;
               data_sent_d = 1'b1;
            end
         end

         DONE: begin
            state_d   = IDLE;
            clk_cnt_d = '0;
            dplus_d   = 1'b1;
            dminus_d  = 1'b0;
         end

         default: begin
            state_d  = IDLE;
            dplus_d  = 1'b1;
            dminus_d = 1'b0;
         end
      endcase

      // Move to the next bit of the word, the next word, or the EOP.
      if (advance) begin
         clk_cnt_d = BIT_LAST;
         if (last_bit) begin
            if (more_words) begin
               state_d     = SHIFT;
               shift_reg_d = {tx_data[7:0], tx_data[15:8]};
               word_cnt_d  = word_cnt_q + WORD_ONE;
               bit_idx_d   = 4'd0;
               next_bit    = tx_data[8];
            end else begin
               state_d   = EOP_SE0;
               clk_cnt_d = SE0_LAST;
               dplus_d   = 1'b0;
               dminus_d  = 1'b0;
            end
         end else begin
            state_d     = SHIFT;
            shift_reg_d = {1'b0, shift_reg_q[15:1]};
            bit_idx_d   = bit_idx_q + 4'd1;
            next_bit    = shift_reg_q[1];
         end
         if ((state_d == SHIFT) && !next_bit) begin
            dplus_d  = ~dplus_q;
            dminus_d = ~dminus_q;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State, counters and all outputs registered together.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         shift_reg_q   <= '0;
         clk_cnt_q     <= '0;
         bit_idx_q     <= '0;
         word_cnt_q    <= '0;
         stuff_cnt_q   <= '0;
         dplus_q       <= 1'b1;
         dminus_q      <= 1'b0;
         read_enable_q <= 1'b0;
         data_sent_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_reg_q   <= shift_reg_d;
         clk_cnt_q     <= clk_cnt_d;
         bit_idx_q     <= bit_idx_d;
         word_cnt_q    <= word_cnt_d;
         stuff_cnt_q   <= stuff_cnt_d;
         dplus_q       <= dplus_d;
         dminus_q      <= dminus_d;
         read_enable_q <= read_enable_d;
         data_sent_q   <= data_sent_d;
         busy_q        <= busy_d;
      end
   end

   assign read_enable = read_enable_q;
   assign data_sent   = data_sent_q;
   assign busy        = busy_q;
   assign dplus       = dplus_q;
   assign dminus      = dminus_q;

endmodule

// File: doc/pd_usb_tx_serializer.md
Name: pd_usb_tx_serializer

Overview:
- Transmit back end of the packet datapath. Consumes the 16-bit word stream produced by the hash separation stage and drives it onto a USB-style differential pair.
- Fetches words with a read_enable pulse and serializes them high byte first, each byte LSB first.
- Applies bit stuffing and NRZI encoding, appends an EOP, then pulses data_sent so the upstream word counter clears.

Parameters:
- CLKS_PER_BIT, 8, clk cycles per line bit (>=2)
- NUM_WORDS, 20, 16-bit words per packet (sync+PID, status, 18 hash words)

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to send a packet; sampled only in IDLE
- tx_data  in  16  current word from upstream; must be stable until read_enable
- read_enable  out  1  one-cycle pulse; word on tx_data consumed, upstream advances
- data_sent  out  1  one-cycle pulse; packet complete (drives upstream clear)
- busy  out  1  high in every state except IDLE
- dplus  out  1  D+ line, registered
- dminus  out  1  D- line, registered

Behaviour:
- Reset: state IDLE; dplus=1, dminus=0 (J, idle); read_enable=0, data_sent=0, busy=0; all counters, shift register and stuff count cleared.
- States: IDLE, LOAD, SHIFT, STUFF, EOP_SE0, EOP_J, DONE.
- IDLE:
  - Line held at J.
  - start=1 -> LOAD.
  - start in any other state is ignored.
- LOAD (1 cycle):
  - read_enable=1.
  - At the edge: shift_reg<=tx_data, word_cnt<=1, bit_idx<=0, stuff_cnt<=0 -> SHIFT.
  - Line stays J.
- SHIFT:
  - Each bit is held CLKS_PER_BIT cycles.
  - Bit order within a word: tx_data[8..15], then tx_data[0..7] (high byte first, LSB first; sync byte 0x80 goes out as 00000001).
  - NRZI: a 0 toggles the line (J<->K); a 1 holds it. K is dplus=0, dminus=1.
  - The line updates on the first clock of each bit period.
- Stuffing:
  - stuff_cnt counts consecutive pre-NRZI 1s across word boundaries. Sync bits are counted.
  - Any 0 bit, data or stuffed, resets stuff_cnt.
  - After the 6th consecutive 1, enter STUFF: one 0 bit (one line toggle) for CLKS_PER_BIT cycles, then resume.
  - This also applies after the final bit of the packet.
- Word advance:
  - Occurs at the last clock of the period of bit 15, or of the STUFF period if a stuff follows bit 15.
  - If word_cnt<NUM_WORDS: read_enable=1 that cycle; at the edge shift_reg<=tx_data and word_cnt++.
  - There is no idle gap between words.
  - If word_cnt==NUM_WORDS: no read_enable; go to EOP_SE0.
- EOP_SE0: dplus=dminus=0 for 2*CLKS_PER_BIT cycles -> EOP_J.
- EOP_J: J for CLKS_PER_BIT cycles -> DONE.
- DONE (1 cycle): data_sent=1, line J -> IDLE.
- Per packet: exactly NUM_WORDS read_enable pulses, one data_sent pulse.
- read_enable and data_sent are never high in the same cycle.
- Reset mid-packet aborts immediately to reset values; no data_sent is produced.
- Counter widths:
  - Bit-period counter: clog2(2*CLKS_PER_BIT).
  - word_cnt: clog2(NUM_WORDS+1).
  - stuff_cnt: 3 bits.

Test Plan:
- Reset with start held high -> dplus=1, dminus=0, busy=0, read_enable=0, data_sent=0; after n_rst rises and start is seen, LOAD starts.
- Packet with word0=0x8000, status=0x0000, hash all 0x0000, start pulse -> line sequence for word0 per bit is K,J,K,J,K,J,K,K,J,K,J,K,J,K,J,K, each 8 clocks; no stuffing.
- Same packet, timing -> read_enable pulses exactly 20 times, first in the LOAD cycle; data_sent rises 2585 edges after the edge that sampled start (1+2560+16+8); preceded by 16 clocks of SE0 then 8 clocks of J.
- All 18 hash words 0xFFFF -> a 0 stuff bit (line toggle) after every 6th consecutive 1, counting across word boundaries; total length grows by the number of stuff bits; the final word advance waits for the trailing stuff period.
- Upstream model alters tx_data only after read_enable -> every received word (NRZI-decoded, de-stuffed) matches the sent word; start pulses during busy are ignored.
- n_rst asserted mid-word 7 -> outputs return to J/0 immediately; no data_sent; a new start sends a full packet correctly.
